lutram_bist: RTL

LUTRAM_BIST -- requirements
Module: lutram_bist

---
 rtl/lutram_bist_pkg.sv | 28 ++
 rtl/lutram_bist_cmp.sv | 64 ++++++
 rtl/lutram_bist.sv | 121 ++++++++++++
 3 files changed

// File: rtl/lutram_bist_pkg.sv
// -----------------------------------------------------------------------------
// lutram_bist_pkg
// Shared definitions for the LUTRAM march-style BIST:
//   state_e      - controller states
//   PAT0 / PAT1  - background patterns for pass 0 and pass 1
//   ERR_CNT_MAX  - saturation value of the mismatch counter
//   exp_data()   - expected array word for an address in a given pass
// -----------------------------------------------------------------------------
package lutram_bist_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WR   = 2'd1,
      S_RD   = 2'd2,
      S_DONE = 2'd3
   } state_e;

   localparam logic [9:0]  PAT0        = 10'h2AA;
   localparam logic [9:0]  PAT1        = 10'h155;
   localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

   // Address bits are XORed with a pass-dependent pattern so that every
   // cell sees both polarities across the two passes.
   function automatic logic [9:0] exp_data(input logic [9:0] a, input logic p);
      return a ^ (p ? PAT1 : PAT0);
   endfunction

endpackage

// File: rtl/lutram_bist_cmp.sv
// -----------------------------------------------------------------------------
// lutram_bist_cmp
// Read-data checker: compares array data with the expected word, counts
// mismatches (saturating), captures the first failing address, keeps a
// sticky fail flag.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   i_clr        start of a new run: clears flag/address, loads i_clr_val
//   i_clr_val    value loaded into the counter at the start of a run
//   i_chk        compare enable (read phase)
//   i_addr       address currently being read
//   i_rdat       data returned by the array
//   i_exp        expected data
//   o_fail       sticky mismatch flag
//   o_err_addr   address of the first mismatch of the run
//   o_err_cnt    saturating mismatch count
// -----------------------------------------------------------------------------
module lutram_bist_cmp
   import lutram_bist_pkg::*;
#(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clr,
   input  logic [15:0]   i_clr_val,
   input  logic          i_chk,
   input  logic [AW-1:0] i_addr,
   input  logic [9:0]    i_rdat,
   input  logic [9:0]    i_exp,
   output logic          o_fail,
   output logic [AW-1:0] o_err_addr,
   output logic [15:0]   o_err_cnt
);

   logic          r_fail;
   logic [AW-1:0] r_err_addr;
   logic [15:0]   r_err_cnt;
   logic          w_mis;

   assign w_mis = i_chk && (i_rdat != i_exp);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fail     <= 1'b0;
         r_err_addr <= '0;
         r_err_cnt  <= '0;
      end else if (i_clr) begin
         r_fail     <= 1'b0;
         r_err_addr <= '0;
         r_err_cnt  <= i_clr_val;
      end else if (w_mis) begin
         if (r_err_cnt != ERR_CNT_MAX) r_err_cnt <= r_err_cnt + 16'd1;
         r_fail <= 1'b1;
         // Only the first failing address of a run is kept.
         if (!r_fail) r_err_addr <= i_addr;
      end
   end

   assign o_fail     = r_fail;
   assign o_err_addr = r_err_addr;
   assign o_err_cnt  = r_err_cnt;

endmodule

// File: rtl/lutram_bist.sv
// -----------------------------------------------------------------------------
// lutram_bist
// Two-pass write/read BIST for an array of LUTRAM16X10 banks of 16x10 LUTRAM.
// Each pass writes the whole array with exp_data(addr, pass) and then reads
// it back, comparing in the same cycle against the asynchronous read data.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   start       run request, accepted in IDLE or DONE
//   addr        array address
//   we, wdat    array write enable / data (write phase only)
//   rdat        combinational array read data
//   busy        high during write and read phases
//   done        high from completion until the next accepted start
//   fail        sticky mismatch flag for the current/last run
//   err_addr    first mismatching address
//   err_cnt     saturating mismatch count
// ERR_CNT_CLR is the counter value loaded when a run starts (normally 0);
// a non-zero value lets a bench reach saturation without a huge array.
// -----------------------------------------------------------------------------
module lutram_bist
   import lutram_bist_pkg::*;
#(
   parameter int          LUTRAM16X10 = 10,
   parameter logic [15:0] ERR_CNT_CLR = 16'h0000,
   localparam int         DEPTH       = LUTRAM16X10 * 16,
   localparam int         AW          = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic [AW-1:0] addr,
   output logic          we,
   output logic [9:0]    wdat,
   input  logic [9:0]    rdat,
   output logic          busy,
   output logic          done,
   output logic          fail,
   output logic [AW-1:0] err_addr,
   output logic [15:0]   err_cnt
);

   state_e        r_state;
   logic          r_pass;
   logic [AW-1:0] r_addr;

   logic          w_in_wr;
   logic          w_in_rd;
   logic          w_start_acc;
   logic          w_last;
   logic [9:0]    w_exp;

   assign w_in_wr     = (r_state == S_WR);
   assign w_in_rd     = (r_state == S_RD);
   assign w_start_acc = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   // Explicit terminal count keeps non-power-of-two depths in range.
   assign w_last      = (r_addr == AW'(DEPTH - 1));
   assign w_exp       = exp_data(10'(r_addr), r_pass);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_pass  <= 1'b0;
         r_addr  <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state <= S_WR;
                  r_pass  <= 1'b0;
                  r_addr  <= '0;
               end
            end
            S_WR: begin
               if (w_last) begin
                  r_state <= S_RD;
                  r_addr  <= '0;
               end else begin
                  r_addr <= r_addr + 1'b1;
               end
            end
            S_RD: begin
               if (w_last) begin
                  r_addr <= '0;
                  if (r_pass) begin
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_WR;
                     r_pass  <= 1'b1;
                  end
               end else begin
                  r_addr <= r_addr + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign addr = r_addr;
   assign we   = w_in_wr;
   assign wdat = w_in_wr ? w_exp : 10'd0;
   assign busy = w_in_wr || w_in_rd;
   assign done = (r_state == S_DONE);

   lutram_bist_cmp #(
      .AW (AW)
   ) u_cmp (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (w_start_acc),
      .i_clr_val  (ERR_CNT_CLR),
      .i_chk      (w_in_rd),
      .i_addr     (r_addr),
      .i_rdat     (rdat),
      .i_exp      (w_exp),
      .o_fail     (fail),
      .o_err_addr (err_addr),
      .o_err_cnt  (err_cnt)
   );

endmodule
